// File: rtl/mux_nx1_scan_if.sv
// Channel bus for mux_nx1_scan: channel data and controls in, sampled data plus tag out.
interface mux_nx1_scan_if #(
  parameter int N_CH    = 8,
  parameter int SEL_W   = 3,
  parameter int DW      = 1,
  parameter int DWELL_W = 8
);
  logic [N_CH*DW-1:0] in;
  logic [SEL_W-1:0]   sel;
  logic               mode;
  logic               start;
  logic [DWELL_W-1:0] dwell;
  logic [N_CH-1:0]    en_mask;
  logic [DW-1:0]      out;
  logic [SEL_W-1:0]   out_ch;
  logic               out_valid;
  logic               busy;
  logic               done;

  modport master (
    output in, sel, mode, start, dwell, en_mask,
    input  out, out_ch, out_valid, busy, done
  );

  modport slave (
    input  in, sel, mode, start, dwell, en_mask,
    output out, out_ch, out_valid, busy, done
  );
endinterface

// File: rtl/mux_nx1_scan.sv
// Registered N:1 mux with manual select and a single ascending masked scan with per-channel dwell.
//   state | meaning
//   IDLE  | manual selection (mode=0) or waiting for start (mode=1)
//   SCAN  | stepping through mask_r, dwell_r samples per channel
module mux_nx1_scan #(
  parameter int N_CH    = 8,
  parameter int SEL_W   = 3,
  parameter int DW      = 1,
  parameter int DWELL_W = 8
) (
  input logic           clk,
  input logic           rst_n,
  mux_nx1_scan_if.slave bus
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t             state;
  logic [DWELL_W-1:0] dwell_r;
  logic [DWELL_W-1:0] cnt;
  logic [N_CH-1:0]    mask_r;
  logic [SEL_W-1:0]   cur_ch;

  logic [DW-1:0]      sel_data;
  logic               sel_ok;
  logic [DW-1:0]      cur_data;
  logic [SEL_W-1:0]   first_ch;
  logic [SEL_W-1:0]   next_ch;
  logic               has_next;
  logic [DWELL_W-1:0] dwell_eff;
  logic               last_dwell;

  // Descending walk so the final hit is the lowest qualifying channel.
  always_comb begin
    sel_data = '0;
    sel_ok   = 1'b0;
    cur_data = '0;
    first_ch = '0;
    next_ch  = '0;
    has_next = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (bus.sel == SEL_W'(k)) begin
        sel_data = bus.in[k*DW +: DW];
        sel_ok   = 1'b1;
      end
      if (cur_ch == SEL_W'(k)) cur_data = bus.in[k*DW +: DW];
    end
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (bus.en_mask[k]) first_ch = SEL_W'(k);
      if (mask_r[k] && (SEL_W'(k) > cur_ch)) begin
        next_ch  = SEL_W'(k);
        has_next = 1'b1;
      end
    end
  end

  assign dwell_eff  = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
  assign last_dwell = (cnt == dwell_r - DWELL_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      dwell_r       <= DWELL_W'(1);
      mask_r        <= '0;
      cur_ch        <= '0;
      cnt           <= '0;
      bus.out       <= '0;
      bus.out_ch    <= '0;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.mode) begin
            bus.out       <= sel_ok ? sel_data : '0;
            bus.out_ch    <= bus.sel;
            bus.out_valid <= sel_ok;
          end else begin
            bus.out_valid <= 1'b0;
            if (bus.start) begin
              dwell_r <= dwell_eff;
              mask_r  <= bus.en_mask;
              if (bus.en_mask == '0) begin
                bus.done <= 1'b1;
              end else begin
                state    <= SCAN;
                bus.busy <= 1'b1;
                cur_ch   <= first_ch;
                cnt      <= '0;
              end
            end
          end
        end
        SCAN: begin
          if (!bus.mode) begin
            // Abort: behave exactly like a manual cycle, no done.
            state         <= IDLE;
            bus.busy      <= 1'b0;
            cnt           <= '0;
            bus.out       <= sel_ok ? sel_data : '0;
            bus.out_ch    <= bus.sel;
            bus.out_valid <= sel_ok;
          end else begin
            bus.out       <= cur_data;
            bus.out_ch    <= cur_ch;
            bus.out_valid <= 1'b1;
            if (last_dwell) begin
              cnt <= '0;
              if (has_next) begin
                cur_ch <= next_ch;
              end else begin
                state    <= IDLE;
                bus.busy <= 1'b0;
                bus.done <= 1'b1;
              end
            end else begin
              cnt <= cnt + DWELL_W'(1);
            end
          end
        end
      endcase
    end
  end

endmodule
